// File: rtl/oserdes_ctrl_pkg.sv
// Shared definitions for the OSERDES lane controller.
//   - lane_state_t : 3-bit lane sequencer state encoding (visible on state_o)
//   - TRAIN_WORD_DEF / IDLE_WORD_DEF : default training and fill words
//   - helper functions mapping a state to its serializer reset / enable level
package oserdes_ctrl_pkg;

    localparam int WORD_W = 10;

    typedef enum logic [2:0] {
        ST_IDLE   = 3'd0,
        ST_RESET  = 3'd1,
        ST_SETTLE = 3'd2,
        ST_TRAIN  = 3'd3,
        ST_RUN    = 3'd4
    } lane_state_t;

    localparam logic [WORD_W-1:0] TRAIN_WORD_DEF = 10'h2AA;
    localparam logic [WORD_W-1:0] IDLE_WORD_DEF  = 10'h354;

    // Serializer is held in reset until the RESET phase has elapsed.
    function automatic logic state_ser_rst(input lane_state_t st);
        return (st == ST_IDLE) || (st == ST_RESET);
    endfunction

    // Output buffer is driven only while training or streaming.
    function automatic logic state_ser_oe(input lane_state_t st);
        return (st == ST_TRAIN) || (st == ST_RUN);
    endfunction

endpackage

// File: rtl/sync_2ff.sv
// Two-flop synchronizer for a single asynchronous level.
//   clk   : destination clock
//   rst_n : asynchronous active-low reset, both flops load RST_VAL
//   d     : asynchronous input
//   q     : synchronized output (two clk edges of latency)
module sync_2ff #(
    parameter logic RST_VAL = 1'b0
) (
    input  logic clk,
    input  logic rst_n,
    input  logic d,
    output logic q
);

    logic meta_r;
    logic sync_r;

    // Two-stage capture of the asynchronous input.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            meta_r <= RST_VAL;
            sync_r <= RST_VAL;
        end else begin
            meta_r <= d;
            sync_r <= meta_r;
        end
    end

    assign q = sync_r;

endmodule

// File: rtl/oserdes_lane_ctrl.sv
// Start-up sequencer and word scheduler for one 10:1 DDR serializer lane.
// Sequence: IDLE -> RESET (serializer reset held) -> SETTLE (reset released,
// output off) -> TRAIN (training word, output on) -> RUN (upstream words, or
// the idle word with an underflow count when upstream has nothing).
// Ports:
//   clk_i, rstn_i            : divided clock, async active-low reset
//   enable_i, locked_i       : lane enable (sync), PLL lock (async)
//   s_data_i/s_valid_i/s_ready_o : upstream valid/ready word interface
//   ser_data_o/ser_rst_o/ser_oe_o : registered serializer controls
//   state_o                  : current state encoding
//   underflow_o              : saturating count of RUN cycles without a word
module oserdes_lane_ctrl
    import oserdes_ctrl_pkg::*;
#(
    parameter int          RST_CYCLES    = 8,
    parameter int          SETTLE_CYCLES = 4,
    parameter int          TRAIN_CYCLES  = 16,
    parameter logic [9:0]  TRAIN_WORD    = TRAIN_WORD_DEF,
    parameter logic [9:0]  IDLE_WORD     = IDLE_WORD_DEF,
    parameter int          CNT_W         = 16
) (
    input  logic             clk_i,
    input  logic             rstn_i,
    input  logic             enable_i,
    input  logic             locked_i,
    input  logic [9:0]       s_data_i,
    input  logic             s_valid_i,
    output logic             s_ready_o,
    output logic [9:0]       ser_data_o,
    output logic             ser_rst_o,
    output logic             ser_oe_o,
    output logic [2:0]       state_o,
    output logic [CNT_W-1:0] underflow_o
);

    localparam logic [CNT_W-1:0] RST_LOAD    = CNT_W'(RST_CYCLES - 1);
    localparam logic [CNT_W-1:0] SETTLE_LOAD = CNT_W'(SETTLE_CYCLES - 1);
    localparam logic [CNT_W-1:0] TRAIN_LOAD  = CNT_W'(TRAIN_CYCLES - 1);

    logic             lock_s;
    logic             qual_s;
    logic             accept_s;
    lane_state_t      state_r;
    lane_state_t      state_nxt_s;
    logic [CNT_W-1:0] phase_r;
    logic [CNT_W-1:0] phase_nxt_s;
    logic [9:0]       data_nxt_s;
    logic [CNT_W-1:0] uf_r;
    logic [CNT_W-1:0] uf_nxt_s;
    logic [9:0]       ser_data_r;
    logic             ser_rst_r;
    logic             ser_oe_r;

    sync_2ff #(
        .RST_VAL (1'b0)
    ) u_lock_sync (
        .clk   (clk_i),
        .rst_n (rstn_i),
        .d     (locked_i),
        .q     (lock_s)
    );

    assign qual_s   = lock_s & enable_i;
    // Ready drops in the same cycle qualification is lost, so nothing is
    // accepted on the edge that aborts to IDLE.
    assign s_ready_o = (state_r == ST_RUN) & qual_s;
    assign accept_s  = s_ready_o & s_valid_i;

    // Next state and phase counter; loss of qualification beats counter expiry.
    always_comb begin
        state_nxt_s = state_r;
        phase_nxt_s = phase_r;
        case (state_r)
            ST_IDLE: begin
                if (qual_s) begin
                    state_nxt_s = ST_RESET;
                    phase_nxt_s = RST_LOAD;
                end else begin
                    state_nxt_s = ST_IDLE;
                    phase_nxt_s = '0;
                end
            end
            ST_RESET: begin
                if (!qual_s) begin
                    state_nxt_s = ST_IDLE;
                    phase_nxt_s = '0;
                end else if (phase_r == '0) begin
                    state_nxt_s = ST_SETTLE;
                    phase_nxt_s = SETTLE_LOAD;
                end else begin
                    state_nxt_s = ST_RESET;
                    phase_nxt_s = phase_r - CNT_W'(1);
                end
            end
            ST_SETTLE: begin
                if (!qual_s) begin
                    state_nxt_s = ST_IDLE;
                    phase_nxt_s = '0;
                end else if (phase_r == '0) begin
                    state_nxt_s = ST_TRAIN;
                    phase_nxt_s = TRAIN_LOAD;
                end else begin
                    state_nxt_s = ST_SETTLE;
                    phase_nxt_s = phase_r - CNT_W'(1);
                end
            end
            ST_TRAIN: begin
                if (!qual_s) begin
                    state_nxt_s = ST_IDLE;
                    phase_nxt_s = '0;
                end else if (phase_r == '0) begin
                    state_nxt_s = ST_RUN;
                    phase_nxt_s = '0;
                end else begin
                    state_nxt_s = ST_TRAIN;
                    phase_nxt_s = phase_r - CNT_W'(1);
                end
            end
            ST_RUN: begin
                if (!qual_s) begin
                    state_nxt_s = ST_IDLE;
                end else begin
                    state_nxt_s = ST_RUN;
                end
                phase_nxt_s = '0;
            end
            default: begin
                state_nxt_s = ST_IDLE;
                phase_nxt_s = '0;
            end
        endcase
    end

    // Serializer word for the state being entered on the next edge.
    always_comb begin
        data_nxt_s = IDLE_WORD;
        case (state_nxt_s)
            ST_TRAIN: data_nxt_s = TRAIN_WORD;
            ST_RUN: begin
                if (accept_s) begin
                    data_nxt_s = s_data_i;
                end else begin
                    data_nxt_s = IDLE_WORD;
                end
            end
            default: data_nxt_s = IDLE_WORD;
        endcase
    end

    // Underflow counter: cleared on TRAIN entry, saturating increment in RUN.
    always_comb begin
        uf_nxt_s = uf_r;
        if ((state_nxt_s == ST_TRAIN) && (state_r != ST_TRAIN)) begin
            uf_nxt_s = '0;
        end else if ((state_r == ST_RUN) && qual_s && !s_valid_i && (uf_r != '1)) begin
            uf_nxt_s = uf_r + CNT_W'(1);
        end else begin
            uf_nxt_s = uf_r;
        end
    end

    // State, counters and registered serializer controls.
    always_ff @(posedge clk_i or negedge rstn_i) begin
        if (!rstn_i) begin
            state_r    <= ST_IDLE;
            phase_r    <= '0;
            uf_r       <= '0;
            ser_data_r <= IDLE_WORD;
            ser_rst_r  <= 1'b1;
            ser_oe_r   <= 1'b0;
        end else begin
            state_r    <= state_nxt_s;
            phase_r    <= phase_nxt_s;
            uf_r       <= uf_nxt_s;
            ser_data_r <= data_nxt_s;
            ser_rst_r  <= state_ser_rst(state_nxt_s);
            ser_oe_r   <= state_ser_oe(state_nxt_s);
        end
    end

    assign ser_data_o  = ser_data_r;
    assign ser_rst_o   = ser_rst_r;
    assign ser_oe_o    = ser_oe_r;
    assign state_o     = state_r;
    assign underflow_o = uf_r;

endmodule

// File: tb/tb_oserdes_lane_ctrl.sv
// Self-checking bench for oserdes_lane_ctrl. Two instances share stimulus:
// default parameters and CNT_W=4 (underflow saturation). The reference model
// tracks "cycles since RESET entry" and derives the phase from plain ranges.
module tb_oserdes_lane_ctrl;

    localparam int R    = 8;
    localparam int S    = 4;
    localparam int T    = 16;
    localparam int RUNK = R + S + T;
    localparam logic [9:0] TW = 10'h2AA;
    localparam logic [9:0] IW = 10'h354;

    logic        clk_i = 1'b0;
    logic        rstn_i;
    logic        enable_i;
    logic        locked_i;
    logic [9:0]  s_data_i;
    logic        s_valid_i;

    logic        s_ready_o,  s_ready4;
    logic [9:0]  ser_data_o, ser_data4;
    logic        ser_rst_o,  ser_rst4;
    logic        ser_oe_o,   ser_oe4;
    logic [2:0]  state_o,    state4;
    logic [15:0] underflow_o;
    logic [3:0]  underflow4;

    int tests_run    = 0;
    int tests_failed = 0;

    // Reference model state
    bit         m_act;
    int         m_k;
    bit         lk1, lk2;
    logic [9:0] m_data;
    int         m_uf, m_uf4;
    int         ecnt;

    always #5 clk_i = ~clk_i;

    oserdes_lane_ctrl dut (
        .clk_i(clk_i), .rstn_i(rstn_i), .enable_i(enable_i), .locked_i(locked_i),
        .s_data_i(s_data_i), .s_valid_i(s_valid_i), .s_ready_o(s_ready_o),
        .ser_data_o(ser_data_o), .ser_rst_o(ser_rst_o), .ser_oe_o(ser_oe_o),
        .state_o(state_o), .underflow_o(underflow_o)
    );

    oserdes_lane_ctrl #(.CNT_W(4)) dut4 (
        .clk_i(clk_i), .rstn_i(rstn_i), .enable_i(enable_i), .locked_i(locked_i),
        .s_data_i(s_data_i), .s_valid_i(s_valid_i), .s_ready_o(s_ready4),
        .ser_data_o(ser_data4), .ser_rst_o(ser_rst4), .ser_oe_o(ser_oe4),
        .state_o(state4), .underflow_o(underflow4)
    );

    function automatic int m_state();
        if (!m_act)           return 0;
        else if (m_k < R)     return 1;
        else if (m_k < R + S) return 2;
        else if (m_k < RUNK)  return 3;
        else                  return 4;
    endfunction

    task automatic model_reset();
        m_act  = 1'b0;
        m_k    = 0;
        lk1    = 1'b0;
        lk2    = 1'b0;
        m_data = IW;
        m_uf   = 0;
        m_uf4  = 0;
    endtask

    // One clock edge of the model, using the inputs sampled at that edge.
    task automatic model_step();
        bit qual, in_run, acc;
        int st;
        qual   = lk2 && enable_i;
        in_run = (m_state() == 4);
        acc    = in_run && qual && s_valid_i;
        if (in_run && qual && !s_valid_i) begin
            if (m_uf  < 65535) m_uf++;
            if (m_uf4 < 15)    m_uf4++;
        end
        if (!m_act) begin
            if (qual) begin
                m_act = 1'b1;
                m_k   = 0;
            end
        end else if (!qual) begin
            m_act = 1'b0;
        end else if (m_k < RUNK) begin
            m_k++;
        end
        st = m_state();
        if (st == 3 && m_k == R + S) begin
            m_uf  = 0;
            m_uf4 = 0;
        end
        if (st == 3)                m_data = TW;
        else if (st == 4 && acc)    m_data = s_data_i;
        else                        m_data = IW;
        lk2 = lk1;
        lk1 = locked_i;
        ecnt++;
    endtask

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        tests_run++;
        if (act !== exp) begin
            tests_failed++;
            $display("FAIL %s edge %0d: got %0h want %0h", name, ecnt, act, exp);
        end
    endtask

    task automatic check_all();
        int  st;
        bit  rdy;
        st  = m_state();
        rdy = (st == 4) && lk2 && enable_i;
        chk("state",    32'(state_o),     32'(st));
        chk("ser_rst",  32'(ser_rst_o),   32'(st < 2));
        chk("ser_oe",   32'(ser_oe_o),    32'(st >= 3));
        chk("ser_data", 32'(ser_data_o),  32'(m_data));
        chk("ready",    32'(s_ready_o),   32'(rdy));
        chk("uf",       32'(underflow_o), 32'(m_uf));
        chk("state4",   32'(state4),      32'(st));
        chk("ser_data4",32'(ser_data4),   32'(m_data));
        chk("ready4",   32'(s_ready4),    32'(rdy));
        chk("ser_rst4", 32'(ser_rst4),    32'(st < 2));
        chk("ser_oe4",  32'(ser_oe4),     32'(st >= 3));
        chk("uf4",      32'(underflow4),  32'(m_uf4));
    endtask

    // Advance one clock: model at the rising edge, compare on the falling edge.
    task automatic cycle();
        @(posedge clk_i);
        model_step();
        @(negedge clk_i);
        check_all();
    endtask

    task automatic rand_valid();
        s_valid_i = 1'($urandom_range(0, 3) != 0);
        s_data_i  = 10'($urandom);
    endtask

    initial begin
        int l2, e1, e2;
        rstn_i    = 1'b0;
        enable_i  = 1'b1;
        locked_i  = 1'b0;
        s_valid_i = 1'b0;
        s_data_i  = 10'h000;
        ecnt      = 0;
        model_reset();
        repeat (3) @(negedge clk_i);
        check_all();
        chk("pin_reset_state", 32'(state_o), 32'd0);
        chk("pin_reset_rst",   32'(ser_rst_o), 32'd1);
        rstn_i = 1'b1;

        // Power-up: lock sampled first at edge 10.
        while (ecnt < 9) begin
            cycle();
            rand_valid();
        end
        locked_i = 1'b1;
        while (ecnt < 50) begin
            cycle();
            if (ecnt == 11) chk("pin_pre_reset", 32'(state_o), 32'd0);
            if (ecnt == 12) chk("pin_reset_entry", 32'(state_o), 32'd1);
            if (ecnt == 19) chk("pin_rst_high", 32'(ser_rst_o), 32'd1);
            if (ecnt == 20) chk("pin_rst_fall", 32'(ser_rst_o), 32'd0);
            if (ecnt == 23) chk("pin_oe_low", 32'(ser_oe_o), 32'd0);
            if (ecnt == 24) chk("pin_oe_rise", 32'(ser_oe_o), 32'd1);
            if (ecnt == 24) chk("pin_train_first", 32'(ser_data_o), 32'(TW));
            if (ecnt == 39) chk("pin_train_last", 32'(ser_data_o), 32'(TW));
            if (ecnt == 39) chk("pin_rdy_low", 32'(s_ready_o), 32'd0);
            if (ecnt == 40) chk("pin_rdy_high", 32'(s_ready_o), 32'd1);
            rand_valid();
        end

        // Streaming words, then underflow with saturation on the 4-bit instance.
        s_valid_i = 1'b1; s_data_i = 10'h001; cycle(); chk("pin_word0", 32'(ser_data_o), 32'h001);
        s_data_i = 10'h3FF; cycle(); chk("pin_word1", 32'(ser_data_o), 32'h3FF);
        s_data_i = 10'h155; cycle(); chk("pin_word2", 32'(ser_data_o), 32'h155);
        s_valid_i = 1'b0;
        for (int i = 0; i < 25; i++) begin
            cycle();
            chk("pin_idle_word", 32'(ser_data_o), 32'(IW));
        end
        chk("pin_uf4_sat", 32'(underflow4), 32'd15);

        // Lock loss mid-RUN.
        s_valid_i = 1'b1;
        locked_i  = 1'b0;
        cycle();
        cycle();
        chk("pin_loss_rdy", 32'(s_ready_o), 32'd0);
        chk("pin_loss_state_run", 32'(state_o), 32'd4);
        cycle();
        chk("pin_loss_idle", 32'(state_o), 32'd0);
        chk("pin_loss_rst", 32'(ser_rst_o), 32'd1);
        chk("pin_loss_oe", 32'(ser_oe_o), 32'd0);

        // Re-lock: full sequence, underflow cleared at TRAIN entry.
        locked_i = 1'b1;
        l2 = ecnt + 1;
        while (ecnt < l2 + 30) begin
            cycle();
            if (ecnt == l2 + 2)  chk("pin_relock_reset", 32'(state_o), 32'd1);
            if (ecnt == l2 + 14) chk("pin_relock_train", 32'(state_o), 32'd3);
            if (ecnt == l2 + 14) chk("pin_uf_clear", 32'(underflow_o), 32'd0);
            rand_valid();
        end
        chk("pin_relock_run", 32'(state_o), 32'd4);
        s_valid_i = 1'b0;
        repeat (5) cycle();
        chk("pin_uf5", 32'(underflow_o), 32'd5);
        chk("pin_uf5_4", 32'(underflow4), 32'd5);

        // Enable drop in the last SETTLE cycle goes to IDLE, not TRAIN.
        enable_i = 1'b0;
        cycle();
        enable_i = 1'b1;
        e1 = ecnt + 1;
        while (ecnt < e1 + 11) begin
            cycle();
            rand_valid();
        end
        chk("pin_settle_last", 32'(state_o), 32'd2);
        enable_i = 1'b0;
        cycle();
        chk("pin_abort_settle", 32'(state_o), 32'd0);
        enable_i = 1'b1;

        // Asynchronous reset pulse in TRAIN.
        e2 = ecnt + 1;
        while (ecnt < e2 + 15) begin
            cycle();
            rand_valid();
        end
        chk("pin_in_train", 32'(state_o), 32'd3);
        rstn_i = 1'b0;
        #1;
        model_reset();
        check_all();
        chk("pin_arst_state", 32'(state_o), 32'd0);
        chk("pin_arst_rst", 32'(ser_rst_o), 32'd1);
        chk("pin_arst_oe", 32'(ser_oe_o), 32'd0);
        chk("pin_arst_data", 32'(ser_data_o), 32'(IW));
        chk("pin_arst_uf", 32'(underflow_o), 32'd0);
        #1;
        rstn_i = 1'b1;

        // Randomized lock/enable disturbance.
        for (int i = 0; i < 600; i++) begin
            cycle();
            rand_valid();
            if ($urandom_range(0, 79) == 0) locked_i = ~locked_i;
            if ($urandom_range(0, 59) == 0) enable_i = ~enable_i;
            if (i == 400) begin
                locked_i = 1'b1;
                enable_i = 1'b1;
            end
        end

        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end

endmodule
